// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and FSM state types for the on-chip SRAM slave.
// Contents: burst/response/size encodings, write/read FSM state enums and
// the per-beat address increment helper.
package axi4_pkg;

    localparam logic [1:0] BurstFixed = 2'b00;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    localparam logic [2:0] Size4B     = 3'b010;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } w_state_e;

    typedef enum logic {
        RIdle,
        RData
    } r_state_e;

    // Byte increment applied after each beat; WRAP deliberately behaves as INCR.
    function automatic logic [2:0] addr_step(input logic [1:0] burst);
        return (burst == BurstFixed) ? 3'd0 : 3'd4;
    endfunction

endpackage

// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between the CPU-side master and the SRAM slave.
// Channels: AW (awid/awaddr/awlen/awsize/awburst/awvalid/awready),
//           W  (wdata/wstrb/wlast/wvalid/wready),
//           B  (bid/bresp/bvalid/bready),
//           AR (arid/araddr/arlen/arsize/arburst/arvalid/arready),
//           R  (rid/rdata/rresp/rlast/rvalid/rready).
interface axi4_sram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);

    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_sram_array.sv
// Word-organised RAM: one synchronous byte-enabled write port, one
// asynchronous read port. Contents are never reset.
// Ports: clk; we/waddr/wbe/wdata (write port); raddr -> rdata (read port).
module axi4_sram_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_WORDS  = 1024,
    localparam int unsigned IdxWidth  = $clog2(MEM_WORDS)
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IdxWidth-1:0]     waddr,
    input  logic [DATA_WIDTH/8-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [IdxWidth-1:0]     raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
                if (wbe[i]) begin
                    mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read sees pre-edge contents, so a same-word read and write returns old data.
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by on-chip SRAM. Independent write (WIdle/WData/WResp)
// and read (RIdle/RData) FSMs, INCR/FIXED bursts up to 256 beats at one beat
// per cycle. Beats outside the mapped window return SLVERR and never touch
// memory.
// Ports: aclk, aresetn (async, active-low); s_axi slave modport carrying the
// AW, W, B, AR and R channels.
module axi4_sram_slave
    import axi4_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ID_WIDTH   = 4,
    parameter int unsigned           MEM_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic              aclk,
    input logic              aresetn,
    axi4_sram_slave_if.slave s_axi
);

    localparam int unsigned IdxWidth = $clog2(MEM_WORDS);
    localparam int unsigned WordW    = ADDR_WIDTH - 2;

    // Holds readies low during reset and until the first edge after release.
    logic up_q;

    w_state_e              w_state_q, w_state_d;
    logic [ID_WIDTH-1:0]   wid_q, wid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  werr_q, werr_d;

    r_state_e              r_state_q, r_state_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rerr_q, rerr_d;

    logic [WordW-1:0]      w_word, r_word;
    logic                  w_in_range, r_in_range;
    logic [ADDR_WIDTH-1:0] r_next_addr, r_look_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Write-side word index and range check for the current beat.
    assign w_word     = WordW'((waddr_q - BASE_ADDR) >> 2);
    assign w_in_range = (w_word < WordW'(MEM_WORDS));
    assign mem_we     = (w_state_q == WData) && s_axi.wvalid && w_in_range;

    // Read port looks at araddr while idle, otherwise at the following beat.
    assign r_next_addr = raddr_q + ADDR_WIDTH'(addr_step(rburst_q));
    assign r_look_addr = (r_state_q == RIdle) ? s_axi.araddr : r_next_addr;
    assign r_word      = WordW'((r_look_addr - BASE_ADDR) >> 2);
    assign r_in_range  = (r_word < WordW'(MEM_WORDS));

    axi4_sram_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_array (
        .clk   (aclk),
        .we    (mem_we),
        .waddr (w_word[IdxWidth-1:0]),
        .wbe   (s_axi.wstrb),
        .wdata (s_axi.wdata),
        .raddr (r_word[IdxWidth-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            up_q      <= 1'b0;
            w_state_q <= WIdle;
            wid_q     <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            werr_q    <= 1'b0;
            r_state_q <= RIdle;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            rdata_q   <= '0;
            rerr_q    <= 1'b0;
        end else begin
            up_q      <= 1'b1;
            w_state_q <= w_state_d;
            wid_q     <= wid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            rdata_q   <= rdata_d;
            rerr_q    <= rerr_d;
        end
    end

    // Write FSM next state. Burst length comes from awlen; wlast is not used.
    always_comb begin
        w_state_d = w_state_q;
        wid_d     = wid_q;
        waddr_d   = waddr_q;
        wlen_d    = wlen_q;
        wburst_d  = wburst_q;
        wcnt_d    = wcnt_q;
        werr_d    = werr_q;
        unique case (w_state_q)
            WIdle: begin
                if (up_q && s_axi.awvalid) begin
                    wid_d     = s_axi.awid;
                    waddr_d   = s_axi.awaddr;
                    wlen_d    = s_axi.awlen;
                    wburst_d  = s_axi.awburst;
                    wcnt_d    = '0;
                    werr_d    = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                if (s_axi.wvalid) begin
                    if (!w_in_range) begin
                        werr_d = 1'b1;
                    end
                    waddr_d = waddr_q + ADDR_WIDTH'(addr_step(wburst_q));
                    wcnt_d  = wcnt_q + 8'd1;
                    if (wcnt_q == wlen_q) begin
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                if (s_axi.bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Read FSM next state. rdata is prefetched so each beat is ready one cycle ahead.
    always_comb begin
        r_state_d = r_state_q;
        rid_d     = rid_q;
        raddr_d   = raddr_q;
        rlen_d    = rlen_q;
        rburst_d  = rburst_q;
        rcnt_d    = rcnt_q;
        rdata_d   = rdata_q;
        rerr_d    = rerr_q;
        unique case (r_state_q)
            RIdle: begin
                if (up_q && s_axi.arvalid) begin
                    rid_d     = s_axi.arid;
                    raddr_d   = s_axi.araddr;
                    rlen_d    = s_axi.arlen;
                    rburst_d  = s_axi.arburst;
                    rcnt_d    = '0;
                    rdata_d   = r_in_range ? mem_rdata : '0;
                    rerr_d    = !r_in_range;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (s_axi.rready) begin
                    if (rcnt_q == rlen_q) begin
                        r_state_d = RIdle;
                    end else begin
                        raddr_d = r_next_addr;
                        rcnt_d  = rcnt_q + 8'd1;
                        rdata_d = r_in_range ? mem_rdata : '0;
                        rerr_d  = !r_in_range;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    assign s_axi.awready = up_q && (w_state_q == WIdle);
    assign s_axi.wready  = (w_state_q == WData);
    assign s_axi.bvalid  = (w_state_q == WResp);
    assign s_axi.bid     = wid_q;
    assign s_axi.bresp   = (s_axi.bvalid && werr_q) ? RespSlverr : RespOkay;

    assign s_axi.arready = up_q && (r_state_q == RIdle);
    assign s_axi.rvalid  = (r_state_q == RData);
    assign s_axi.rid     = rid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = (s_axi.rvalid && rerr_q) ? RespSlverr : RespOkay;
    assign s_axi.rlast   = s_axi.rvalid && (rcnt_q == rlen_q);

endmodule
